sp_ram_responder: RTL and testbench
===================================

Name: sp_ram_responder

Overview:
- Memory-side responder for one sp_ram_intf bus, i.e. the end that the Conv bus switcher's external param/bias/weight/input/output buses drive.
- Backs the bus with a register-array word store. Adds a host fill/drain port (valid/ready) so the CPU/DMA can preload and read back buffers.
- Arbitrates between the compute side and the host side; the compute side always wins.

Parameters:
- ADDR_W, 16, sp_ram_intf address width in words.
- DATA_W, 32, word width; must be a multiple of 8.
- DEPTH, 1024, number of words implemented; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  compute chip select (sp_ram_intf memory modport).
- oe  in  1  compute read output enable.
- addr  in  ADDR_W  compute word address.
- W_req  in  DATA_W/8  per-byte write strobe, active-low; all-ones = `WRITE_DIS.
- W_data  in  DATA_W  compute write data.
- R_data  out  DATA_W  compute read data.
- host_req_valid  in  1  host request valid.
- host_req_ready  out  1  host request accepted this cycle.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data (full-word writes only).
- host_rsp_valid  out  1  host response valid (issued for reads and for writes).
- host_rsp_ready  in  1  host accepts the response.
- host_rdata  out  DATA_W  host read data; 0 for writes.
- addr_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset values:
  - R_data = 0, host_rsp_valid = 0, host_rdata = 0, addr_err = 0.
  - FSM = IDLE.
  - Storage is not reset.
- Compute access happens when cs = 1:
  - Write when W_req != `WRITE_DIS. Each byte lane whose strobe is 0 is written at the clock edge.
  - Read when oe = 1 and W_req == `WRITE_DIS. R_data = mem[addr] is registered, valid the cycle after the request (latency 1).
  - If oe = 1 and some strobes are active in the same cycle, the write wins and R_data holds its value.
  - In any cycle with no compute read, R_data holds its last value.
- Host arbitration:
  - host_req_ready = (state == IDLE) && !cs. This is combinational on cs and state.
  - A handshake (valid && ready) performs the access in that cycle: a write stores host_wdata to all lanes; a read latches mem[host_addr] into host_rdata.
- FSM:
  - IDLE -> RSP on a host handshake; host_rsp_valid = 1 the next cycle.
  - RSP -> IDLE when host_rsp_ready = 1. host_rdata and host_rsp_valid stay stable until then.
  - Only one host transaction is outstanding at a time.
- Same address in the same cycle: impossible for compute and host, because host_req_ready = 0 whenever cs = 1.
- Read-after-write on the compute side: a read in cycle n+1 of an address written in cycle n returns the new data.
- Out of range (addr >= DEPTH) on either side:
  - Writes are dropped; reads return 0.
  - addr_err is set and stays set until rst.
  - The host still receives a response.
- Reset mid-transaction: a pending host response is discarded and the FSM returns to IDLE.

Optional Feature:
- Macro: SP_RAM_PERF_CNT_EN.
- When defined, adds outputs perf_rd_cnt[31:0] and perf_wr_cnt[31:0]. They count accepted compute reads and compute writes, saturate at 0xFFFFFFFF, and reset to 0.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package ConvAcc.svh holds:
  - `WRITE_DIS / `WRITE_ENB.
  - The host FSM state enum {IDLE, RSP}.
  - The per-lane byte-strobe width macro.
- One sub-module, sp_ram_bytewrite_array:
  - DEPTH x DATA_W storage with a single write port carrying an active-low byte strobe.
  - Two combinational read ports (compute, host).
  - Registering is done in the parent.

Test Plan:
- Byte write then read: compute write addr 5, W_data 0xAABBCCDD, W_req 4'b0000; then W_req 4'b1100, W_data 0x11223344; then a read of addr 5 -> R_data = 0xAABB3344 exactly one cycle after the read.
- Host preload and compute read: host writes 0xDEADBEEF to addr 10 (rsp_valid the next cycle, rsp_ready = 1); compute reads 10 -> 0xDEADBEEF.
- Contention: cs = 1 held for 3 cycles with host_req_valid = 1 -> host_req_ready = 0 for those 3 cycles. Handshake occurs the cycle after cs drops.
- Response backpressure: host read of addr 10 with host_rsp_ready = 0 for 4 cycles -> host_rsp_valid stays 1, host_rdata stays 0xDEADBEEF, host_req_ready = 0; response clears on the ready cycle.
- Out of range (DEPTH = 1024): compute write addr 1024 then a read of addr 1024 -> R_data = 0, addr_err = 1 and stays 1 until rst; addr 0 contents unchanged.
- Reset while in RSP: assert rst -> next cycle host_rsp_valid = 0, R_data = 0, addr_err = 0, host_req_ready = 1.

Source files
------------

// File: rtl/sp_ram_responder_pkg.sv
// sp_ram_responder_pkg
// Shared definitions for the sp_ram_responder slice.
//   `WRITE_DIS / `WRITE_ENB : all-lanes-off / all-lanes-on values for the
//                             active-low byte strobe (width-agnostic fills)
//   `SP_RAM_BYTE_W          : width of one strobe lane in bits
//   host_state_e            : host-port transaction FSM states
//   idx_width()             : storage index width for a given depth
// Optional feature macro used by the slice: SP_RAM_PERF_CNT_EN.

`ifndef SP_RAM_RESPONDER_DEFS
`define SP_RAM_RESPONDER_DEFS
`define WRITE_DIS '1
`define WRITE_ENB '0
`define SP_RAM_BYTE_W 8
`endif

package sp_ram_responder_pkg;

  typedef enum logic {
    IDLE,
    RSP
  } host_state_e;

  localparam int BYTE_W = `SP_RAM_BYTE_W;

  // A single-word store still needs a one-bit index to stay legal.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_bytewrite_array.sv
// sp_ram_bytewrite_array
// DEPTH x DATA_W register-array word store with one byte-strobed write port
// and two combinational read ports. Range checking and read registering are
// the parent's job; indices arriving here are assumed in range.
// Ports:
//   clk        clock
//   wr_strb    active-low per-lane write strobe (all ones = no write)
//   wr_idx     write word index
//   wr_data    write data
//   rd_idx_a   compute-side read index,  rd_data_a its word
//   rd_idx_b   host-side read index,     rd_data_b its word

module sp_ram_bytewrite_array
  import sp_ram_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic                       clk,
  input  logic [DATA_W/BYTE_W-1:0]   wr_strb,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [IDX_W-1:0]           rd_idx_a,
  output logic [DATA_W-1:0]          rd_data_a,
  input  logic [IDX_W-1:0]           rd_idx_b,
  output logic [DATA_W-1:0]          rd_data_b
);

  localparam int LANES = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; each lane is written only when its
  // strobe bit is low.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (!wr_strb[l]) begin
        mem[wr_idx][l*BYTE_W +: BYTE_W] <= wr_data[l*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rd_data_a = mem[rd_idx_a];
  assign rd_data_b = mem[rd_idx_b];

endmodule

// File: rtl/sp_ram_responder.sv
// sp_ram_responder
// Memory-side responder for one sp_ram_intf bus plus a host fill/drain port.
// The compute side always wins: the host is only accepted when cs is low.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cs, oe, addr      compute chip select, read enable, word address
//   W_req, W_data     compute active-low byte strobes and write data
//   R_data            registered compute read data (latency 1)
//   host_req_*        host request handshake, host_we/addr/wdata request
//   host_rsp_*        host response handshake, host_rdata response data
//   addr_err          sticky out-of-range flag
// Optional feature: define SP_RAM_PERF_CNT_EN to add saturating
// perf_rd_cnt / perf_wr_cnt counters of compute reads and writes.

module sp_ram_responder
  import sp_ram_responder_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     oe,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W/BYTE_W-1:0] W_req,
  input  logic [DATA_W-1:0]        W_data,
  output logic [DATA_W-1:0]        R_data,
  input  logic                     host_req_valid,
  output logic                     host_req_ready,
  input  logic                     host_we,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [DATA_W-1:0]        host_wdata,
  output logic                     host_rsp_valid,
  input  logic                     host_rsp_ready,
  output logic [DATA_W-1:0]        host_rdata,
  output logic                     addr_err
`ifdef SP_RAM_PERF_CNT_EN
  ,
  output logic [31:0]              perf_rd_cnt,
  output logic [31:0]              perf_wr_cnt
`endif
);

  localparam int LANES = DATA_W / BYTE_W;
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  host_state_e state_q, state_d;

  logic comp_oor, host_oor;
  logic comp_wr, comp_rd, host_hs, host_wr;
  logic [LANES-1:0]  arr_strb;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_data;
  logic [DATA_W-1:0] comp_word, host_word;

  assign comp_oor = {1'b0, addr} >= DEPTH_LIM;
  assign host_oor = {1'b0, host_addr} >= DEPTH_LIM;
  assign comp_wr  = cs && (W_req != `WRITE_DIS);
  assign comp_rd  = cs && oe && (W_req == `WRITE_DIS);
  assign host_hs  = host_req_valid && host_req_ready;
  assign host_wr  = host_hs && host_we;

  // The single write port is shared; cs and a host handshake never coincide,
  // and out-of-range writes simply leave every strobe disabled.
  always_comb begin
    arr_strb = `WRITE_DIS;
    arr_idx  = addr[IDX_W-1:0];
    arr_data = W_data;
    if (comp_wr && !comp_oor) begin
      arr_strb = W_req;
    end else if (host_wr && !host_oor) begin
      arr_strb = `WRITE_ENB;
      arr_idx  = host_addr[IDX_W-1:0];
      arr_data = host_wdata;
    end
  end

  sp_ram_bytewrite_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk       (clk),
    .wr_strb   (arr_strb),
    .wr_idx    (arr_idx),
    .wr_data   (arr_data),
    .rd_idx_a  (addr[IDX_W-1:0]),
    .rd_data_a (comp_word),
    .rd_idx_b  (host_addr[IDX_W-1:0]),
    .rd_data_b (host_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Host FSM: one outstanding transaction; ready is combinational on cs so
  // the compute side can pre-empt the host in the same cycle.
  always_comb begin
    state_d        = state_q;
    host_req_ready = 1'b0;
    host_rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        host_req_ready = !cs;
        if (host_req_valid && !cs) begin
          state_d = RSP;
        end
      end
      RSP: begin
        host_rsp_valid = 1'b1;
        if (host_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // R_data only moves on a pure compute read; writes (even with oe) hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      R_data <= '0;
    end else if (comp_rd) begin
      R_data <= comp_oor ? '0 : comp_word;
    end
  end

  // host_rdata is captured at the handshake and held through the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata <= '0;
    end else if (host_hs) begin
      host_rdata <= (host_we || host_oor) ? '0 : host_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (((comp_wr || comp_rd) && comp_oor) || (host_hs && host_oor)) begin
      addr_err <= 1'b1;
    end
  end

`ifdef SP_RAM_PERF_CNT_EN
  // Saturating event counters for compute-side accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else begin
      if (comp_rd && (perf_rd_cnt != 32'hFFFF_FFFF)) begin
        perf_rd_cnt <= perf_rd_cnt + 32'd1;
      end
      if (comp_wr && (perf_wr_cnt != 32'hFFFF_FFFF)) begin
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      end
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_sp_ram_responder.sv
// tb_sp_ram_responder
// Self-checking bench for sp_ram_responder: a constant vector table for the
// compute port, hand-written host/contention/range/reset sequences, and a
// randomized phase checked against a word-array reference model.

module tb_sp_ram_responder;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LANES  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cs, oe;
  logic [ADDR_W-1:0] addr;
  logic [LANES-1:0]  W_req;
  logic [DATA_W-1:0] W_data, R_data;
  logic              host_req_valid, host_req_ready, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic              host_rsp_valid, host_rsp_ready;
  logic              addr_err;
`ifdef SP_RAM_PERF_CNT_EN
  logic [31:0]       perf_rd_cnt, perf_wr_cnt;
`endif

  sp_ram_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cs             (cs),
    .oe             (oe),
    .addr           (addr),
    .W_req          (W_req),
    .W_data         (W_data),
    .R_data         (R_data),
    .host_req_valid (host_req_valid),
    .host_req_ready (host_req_ready),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_ready (host_rsp_ready),
    .host_rdata     (host_rdata),
    .addr_err       (addr_err)
`ifdef SP_RAM_PERF_CNT_EN
    ,
    .perf_rd_cnt    (perf_rd_cnt),
    .perf_wr_cnt    (perf_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus the expected held R_data and error flag.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_r_data;
  logic        exp_err;

  typedef struct {
    logic        cs;
    logic        oe;
    logic [15:0] addr;
    logic [3:0]  w_req;
    logic [31:0] w_data;
    logic [31:0] exp_r_data;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected effect of one compute cycle, derived from the access rules.
  task automatic modelCompute(input logic c, input logic o, input logic [15:0] a,
                              input logic [3:0] wr, input logic [31:0] wd);
    if (c) begin
      if (wr != 4'hF) begin
        if (a < DEPTH) begin
          for (int l = 0; l < LANES; l++)
            if (!wr[l]) model_mem[a][l*8 +: 8] = wd[l*8 +: 8];
        end else begin
          exp_err = 1'b1;
        end
      end else if (o) begin
        if (a < DEPTH) begin
          exp_r_data = model_mem[a];
        end else begin
          exp_r_data = 32'h0;
          exp_err    = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic c, input logic o, input logic [15:0] a,
                               input logic [3:0] wr, input logic [31:0] wd);
    cs     = c;
    oe     = o;
    addr   = a;
    W_req  = wr;
    W_data = wd;
    modelCompute(c, o, a, wr, wd);
    tick();
  endtask

  // One complete host transaction with a given number of backpressure cycles.
  task automatic hostAccess(input logic we, input logic [15:0] a,
                            input logic [31:0] wd, input int stall);
    logic [31:0] exp_rd;
    cs             = 1'b0;
    oe             = 1'b0;
    W_req          = 4'hF;
    host_req_valid = 1'b1;
    host_we        = we;
    host_addr      = a;
    host_wdata     = wd;
    host_rsp_ready = 1'b0;
    #1;
    checkOutput("host_req_ready idle", {31'b0, host_req_ready}, 32'd1);
    if (a >= DEPTH) begin
      exp_err = 1'b1;
      exp_rd  = 32'h0;
    end else if (we) begin
      model_mem[a] = wd;
      exp_rd       = 32'h0;
    end else begin
      exp_rd = model_mem[a];
    end
    tick();
    host_req_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      checkOutput("host_rsp_valid held", {31'b0, host_rsp_valid}, 32'd1);
      checkOutput("host_rdata held", host_rdata, exp_rd);
      checkOutput("host_req_ready busy", {31'b0, host_req_ready}, 32'd0);
      tick();
    end
    host_rsp_ready = 1'b1;
    checkOutput("host_rsp_valid", {31'b0, host_rsp_valid}, 32'd1);
    checkOutput("host_rdata", host_rdata, exp_rd);
    tick();
    host_rsp_ready = 1'b0;
    checkOutput("host_rsp_valid cleared", {31'b0, host_rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    int          kind;

    rst            = 1'b1;
    cs             = 1'b0;
    oe             = 1'b0;
    addr           = '0;
    W_req          = 4'hF;
    W_data         = '0;
    host_req_valid = 1'b0;
    host_we        = 1'b0;
    host_addr      = '0;
    host_wdata     = '0;
    host_rsp_ready = 1'b0;
    exp_r_data     = 32'h0;
    exp_err        = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset state
    tick();
    tick();
    checkOutput("reset R_data", R_data, 32'h0);
    checkOutput("reset host_rsp_valid", {31'b0, host_rsp_valid}, 32'd0);
    checkOutput("reset host_rdata", host_rdata, 32'h0);
    checkOutput("reset addr_err", {31'b0, addr_err}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset host_req_ready", {31'b0, host_req_ready}, 32'd1);

    // Compute-port vector table
    vecs[0] = '{1'b1, 1'b0, 16'd5, 4'b0000, 32'hAABBCCDD, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 16'd5, 4'b1100, 32'h11223344, 32'h00000000};
    vecs[2] = '{1'b1, 1'b1, 16'd5, 4'b1111, 32'h00000000, 32'hAABB3344};
    vecs[3] = '{1'b0, 1'b1, 16'd5, 4'b1111, 32'h00000000, 32'hAABB3344};
    vecs[4] = '{1'b1, 1'b1, 16'd6, 4'b0000, 32'h12345678, 32'hAABB3344};
    vecs[5] = '{1'b1, 1'b1, 16'd6, 4'b1111, 32'h00000000, 32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 16'd5, 4'b1111, 32'h00000000, 32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 16'd6, 4'b1110, 32'h000000FF, 32'h12345678};
    vecs[8] = '{1'b1, 1'b1, 16'd6, 4'b1111, 32'h00000000, 32'h123456FF};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].cs, vecs[i].oe, vecs[i].addr, vecs[i].w_req, vecs[i].w_data);
      checkOutput($sformatf("vec%0d R_data", i), R_data, vecs[i].exp_r_data);
    end

    // Host preload then compute read
    hostAccess(1'b1, 16'd10, 32'hDEADBEEF, 0);
    applyStimulus(1'b1, 1'b1, 16'd10, 4'hF, 32'h0);
    checkOutput("compute read of host preload", R_data, 32'hDEADBEEF);

    // Contention: host waits while cs is held, then handshakes with backpressure
    host_req_valid = 1'b1;
    host_we        = 1'b0;
    host_addr      = 16'd10;
    for (int i = 0; i < 3; i++) begin
      cs    = 1'b1;
      oe    = 1'b1;
      addr  = 16'd10;
      W_req = 4'hF;
      #1;
      checkOutput($sformatf("contention ready cycle%0d", i), {31'b0, host_req_ready}, 32'd0);
      modelCompute(1'b1, 1'b1, 16'd10, 4'hF, 32'h0);
      tick();
    end
    hostAccess(1'b0, 16'd10, 32'h0, 4);

    // Randomized phase against the model
    for (int i = 0; i < 32; i++) hostAccess(1'b1, 16'(i), $urandom, 0);
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 4);
      ra   = 16'($urandom_range(0, 31));
      case (kind)
        0: begin
          applyStimulus(1'b1, 1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 14)), $urandom);
          checkOutput("rand write R_data hold", R_data, exp_r_data);
        end
        1: begin
          applyStimulus(1'b1, 1'b1, ra, 4'hF, $urandom);
          checkOutput("rand read R_data", R_data, exp_r_data);
        end
        2: hostAccess(1'b1, ra, $urandom, $urandom_range(0, 2));
        3: hostAccess(1'b0, ra, 32'h0, $urandom_range(0, 2));
        default: begin
          applyStimulus(1'b0, 1'b1, ra, 4'hF, $urandom);
          checkOutput("rand idle R_data hold", R_data, exp_r_data);
        end
      endcase
    end
    checkOutput("rand addr_err", {31'b0, addr_err}, {31'b0, exp_err});

    // Out of range
    applyStimulus(1'b1, 1'b0, 16'd1024, 4'b0000, 32'h55555555);
    checkOutput("oor write addr_err", {31'b0, addr_err}, 32'd1);
    applyStimulus(1'b1, 1'b1, 16'd1024, 4'hF, 32'h0);
    checkOutput("oor read R_data", R_data, 32'h0);
    checkOutput("oor read addr_err", {31'b0, addr_err}, 32'd1);
    applyStimulus(1'b1, 1'b1, 16'd0, 4'hF, 32'h0);
    checkOutput("addr0 unchanged", R_data, model_mem[0]);
    hostAccess(1'b0, 16'd2000, 32'h0, 1);
    hostAccess(1'b1, 16'hFFFF, 32'hCAFEF00D, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'd0, 4'hF, 32'h0);
    checkOutput("addr_err sticky", {31'b0, addr_err}, {31'b0, exp_err});

    // Reset while a host response is pending
    host_req_valid = 1'b1;
    host_we        = 1'b0;
    host_addr      = 16'd1;
    host_rsp_ready = 1'b0;
    tick();
    host_req_valid = 1'b0;
    checkOutput("pre-reset rsp_valid", {31'b0, host_rsp_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_r_data = 32'h0;
    exp_err    = 1'b0;
    #1;
    checkOutput("rsp reset host_rsp_valid", {31'b0, host_rsp_valid}, 32'd0);
    checkOutput("rsp reset R_data", R_data, 32'h0);
    checkOutput("rsp reset addr_err", {31'b0, addr_err}, 32'd0);
    checkOutput("rsp reset host_req_ready", {31'b0, host_req_ready}, 32'd1);
    hostAccess(1'b0, 16'd1, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
